// File: rtl/an_rx_pkg.sv
// Shared types and width helpers for the multi-tone 1-bit mic level detector.
package an_rx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Signed I/Q and the unsigned |I|+|Q| magnitude both fit in win_log+2 bits.
   function automatic int mag_w(input int win_log);
      return win_log + 2;
   endfunction

endpackage

// File: rtl/an_rx_tone_corr.sv
// One tone channel: phase accumulator, I/Q square-wave correlators and saturated magnitude.
module an_rx_tone_corr
   import an_rx_pkg::*;
#(
   parameter int C_PH_W    = 16,
   parameter int C_WIN_LOG = 12,
   parameter int C_LV_W    = 12
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              smp,
   input  logic              first,
   input  logic              last,
   input  logic              mic,
   input  logic [C_PH_W-1:0] inc_in,
   output logic [C_LV_W-1:0] lv
);

   localparam int AW = mag_w(C_WIN_LOG);
   localparam int CW = (AW > C_LV_W) ? AW : C_LV_W;
   localparam logic signed [AW-1:0] ONE    = AW'(1);
   localparam logic [C_LV_W-1:0]    LV_MAX = '1;

   logic [C_PH_W-1:0]    ph;
   logic [C_PH_W-1:0]    inc;
   logic signed [AW-1:0] acc_i;
   logic signed [AW-1:0] acc_q;
   logic signed [AW-1:0] i_nxt;
   logic signed [AW-1:0] q_nxt;
   logic                 ref_i;
   logic                 ref_q;
   logic [AW-1:0]        abs_i;
   logic [AW-1:0]        abs_q;
   logic [AW-1:0]        mag;
   logic [CW-1:0]        mag_x;

   // Level is derived from the post-sample sums so the final sample of a window is included.
   always_comb begin
      ref_i = ~ph[C_PH_W-1];
      ref_q = ph[C_PH_W-1] ^ ph[C_PH_W-2];
      i_nxt = (mic == ref_i) ? acc_i + ONE : acc_i - ONE;
      q_nxt = (mic == ref_q) ? acc_q + ONE : acc_q - ONE;
      abs_i = i_nxt[AW-1] ? AW'(-i_nxt) : AW'(i_nxt);
      abs_q = q_nxt[AW-1] ? AW'(-q_nxt) : AW'(q_nxt);
      mag   = abs_i + abs_q;
      mag_x = CW'(mag);
      lv    = (mag_x > CW'(LV_MAX)) ? LV_MAX : C_LV_W'(mag_x);
   end

   // Phase is zero at every window start, so loading inc_in yields the post-first-sample phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         ph    <= '0;
         inc   <= '0;
         acc_i <= '0;
         acc_q <= '0;
      end else if (smp) begin
         if (first) inc <= inc_in;
         if (last) begin
            ph    <= '0;
            acc_i <= '0;
            acc_q <= '0;
         end else begin
            acc_i <= i_nxt;
            acc_q <= q_nxt;
            ph    <= first ? inc_in : ph + inc;
         end
      end
   end

endmodule

// File: rtl/an_rx_lv_det_mt.sv
// Multi-tone PDM mic level detector: mic clock divider, window FSM, per-tone levels and hysteresis flags.
module an_rx_lv_det_mt
   import an_rx_pkg::*;
#(
   parameter int C_MIC_DIV = 16,
   parameter int C_N_TONE  = 4,
   parameter int C_PH_W    = 16,
   parameter int C_WIN_LOG = 12,
   parameter int C_LV_W    = 12
)(
   input  logic                       CK_i,
   input  logic                       RST_i,
   input  logic                       MIC_i,
   output logic                       MIC_CK_o,
   input  logic [C_N_TONE*C_PH_W-1:0] TONE_INCs_i,
   input  logic [C_LV_W-1:0]          THR_ON_i,
   input  logic [C_LV_W-1:0]          THR_OFF_i,
   input  logic                       CONT_i,
   input  logic                       START_i,
   output logic                       BUSY_o,
   output logic [C_N_TONE*C_LV_W-1:0] LVs_o,
   output logic [C_N_TONE-1:0]        LV_FLGs_o,
   output logic                       DONE_o
);

   localparam int DW = clog2_f(C_MIC_DIV);

   logic [DW-1:0]              div_cnt;
   logic [DW-1:0]              div_nxt;
   logic                       smp;
   state_t                     state;
   state_t                     state_nxt;
   logic [C_WIN_LOG-1:0]       smp_cnt;
   logic                       smp_act;
   logic                       win_first;
   logic                       smp_last;
   logic [C_LV_W-1:0]          thr_on;
   logic [C_LV_W-1:0]          thr_off;
   logic [C_N_TONE*C_LV_W-1:0] lv_now;
   logic [C_N_TONE-1:0]        flg_nxt;

   assign div_nxt = (div_cnt == DW'(C_MIC_DIV - 1)) ? '0 : div_cnt + DW'(1);
   assign smp     = (div_cnt == DW'(C_MIC_DIV - 1));

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         div_cnt  <= '0;
         MIC_CK_o <= 1'b0;
      end else begin
         div_cnt  <= div_nxt;
         MIC_CK_o <= (div_nxt >= DW'(C_MIC_DIV / 2));
      end
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (smp && (CONT_i || START_i)) state_nxt = ST_RUN;
         ST_RUN:  if (smp_last && !CONT_i)        state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // smp_cnt is zero only on a window's first sample, whether entered from IDLE or back-to-back.
   always_comb begin
      BUSY_o    = (state == ST_RUN);
      smp_act   = smp && ((state == ST_RUN) || CONT_i || START_i);
      win_first = smp_act && (smp_cnt == '0);
      smp_last  = smp_act && (smp_cnt == '1);
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         smp_cnt <= '0;
         thr_on  <= '0;
         thr_off <= '0;
      end else if (smp_act) begin
         smp_cnt <= smp_last ? '0 : smp_cnt + C_WIN_LOG'(1);
         if (win_first) begin
            thr_on  <= THR_ON_i;
            thr_off <= THR_OFF_i;
         end
      end
   end

   for (genvar k = 0; k < C_N_TONE; k++) begin : g_tone
      an_rx_tone_corr #(
         .C_PH_W    (C_PH_W),
         .C_WIN_LOG (C_WIN_LOG),
         .C_LV_W    (C_LV_W)
      ) u_corr (
         .clk    (CK_i),
         .rst    (RST_i),
         .smp    (smp_act),
         .first  (win_first),
         .last   (smp_last),
         .mic    (MIC_i),
         .inc_in (TONE_INCs_i[k*C_PH_W +: C_PH_W]),
         .lv     (lv_now[k*C_LV_W +: C_LV_W])
      );
   end

   // Set is tested first so it wins when the thresholds overlap.
   always_comb begin
      flg_nxt = LV_FLGs_o;
      for (int k = 0; k < C_N_TONE; k++) begin
         if (lv_now[k*C_LV_W +: C_LV_W] >= thr_on)      flg_nxt[k] = 1'b1;
         else if (lv_now[k*C_LV_W +: C_LV_W] < thr_off) flg_nxt[k] = 1'b0;
      end
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         LVs_o     <= '0;
         LV_FLGs_o <= '0;
         DONE_o    <= 1'b0;
      end else begin
         DONE_o <= smp_last;
         if (smp_last) begin
            LVs_o     <= lv_now;
            LV_FLGs_o <= flg_nxt;
         end
      end
   end

endmodule

// File: tb/tb_an_rx_lv_det_mt.sv
// Self-checking bench for an_rx_lv_det_mt: vector table of whole windows, scoreboard checked on DONE.
module tb_an_rx_lv_det_mt;

   localparam int C_MIC_DIV = 4;
   localparam int C_N_TONE  = 2;
   localparam int C_PH_W    = 16;
   localparam int C_WIN_LOG = 8;
   localparam int C_LV_W    = 12;
   localparam int WIN       = 1 << C_WIN_LOG;

   logic                       CK_i;
   logic                       RST_i;
   logic                       MIC_i;
   logic                       MIC_CK_o;
   logic [C_N_TONE*C_PH_W-1:0] TONE_INCs_i;
   logic [C_LV_W-1:0]          THR_ON_i;
   logic [C_LV_W-1:0]          THR_OFF_i;
   logic                       CONT_i;
   logic                       START_i;
   logic                       BUSY_o;
   logic [C_N_TONE*C_LV_W-1:0] LVs_o;
   logic [C_N_TONE-1:0]        LV_FLGs_o;
   logic                       DONE_o;

   typedef enum {MK_TONE, MK_ONE} mic_kind_t;

   typedef struct {
      mic_kind_t   kind;
      int          k_match;
      logic [15:0] inc0;
      logic [15:0] inc1;
      logic [11:0] thr_on;
      logic [11:0] thr_off;
      int          exp_lv0;
      int          exp_lv1;
      logic [1:0]  exp_flg;
   } vec_t;

   typedef struct {
      int         lv0;
      int         lv1;
      logic [1:0] flg;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;
   int   div_m    = 0;
   int   busy_cnt;

   an_rx_lv_det_mt #(
      .C_MIC_DIV (C_MIC_DIV),
      .C_N_TONE  (C_N_TONE),
      .C_PH_W    (C_PH_W),
      .C_WIN_LOG (C_WIN_LOG),
      .C_LV_W    (C_LV_W)
   ) dut (
      .CK_i        (CK_i),
      .RST_i       (RST_i),
      .MIC_i       (MIC_i),
      .MIC_CK_o    (MIC_CK_o),
      .TONE_INCs_i (TONE_INCs_i),
      .THR_ON_i    (THR_ON_i),
      .THR_OFF_i   (THR_OFF_i),
      .CONT_i      (CONT_i),
      .START_i     (START_i),
      .BUSY_o      (BUSY_o),
      .LVs_o       (LVs_o),
      .LV_FLGs_o   (LV_FLGs_o),
      .DONE_o      (DONE_o)
   );

   initial CK_i = 1'b0;
   always #5 CK_i = ~CK_i;

   // Reference divider phase: the cycle with div_m == C_MIC_DIV-1 ends in a sampling edge.
   always @(posedge CK_i) begin
      if (RST_i) div_m <= 0;
      else       div_m <= (div_m + 1) % C_MIC_DIV;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Mic bit for sample n: in phase with a 16-sample tone for the first k_match samples, alternating after.
   function automatic logic micFor(input mic_kind_t kind, input int k_match, input int n);
      if (kind == MK_ONE) return 1'b1;
      if (n < k_match)    return ((n >> 3) & 1) == 0;
      return (n & 1) == 0;
   endfunction

   task automatic smp(input logic mic);
      while (div_m != C_MIC_DIV - 1) begin
         @(posedge CK_i);
         #1;
      end
      MIC_i = mic;
      @(posedge CK_i);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v, input bit drop_cont);
      TONE_INCs_i = {v.inc1, v.inc0};
      THR_ON_i    = v.thr_on;
      THR_OFF_i   = v.thr_off;
      sb.push_back('{lv0: v.exp_lv0, lv1: v.exp_lv1, flg: v.exp_flg});
      for (int n = 0; n < WIN; n++) begin
         smp(micFor(v.kind, v.k_match, n));
         if (n == 0 && drop_cont) CONT_i = 1'b0;
         if (n == 10) checkOutput("busy_mid_window", BUSY_o, 1);
      end
   endtask

   always @(negedge CK_i) begin
      if (DONE_o) begin
         n_done++;
         checkOutput("done_expected", (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("lv0", int'(LVs_o[0 +: C_LV_W]), mon_e.lv0);
            checkOutput("lv1", int'(LVs_o[C_LV_W +: C_LV_W]), mon_e.lv1);
            checkOutput("flags", int'(LV_FLGs_o), int'(mon_e.flg));
         end
      end
   end

   initial begin
      vecs[0] = '{MK_TONE, 256, 16'h1000, 16'h0800, 12'd300, 12'd10,  256, 0,   2'b00};
      vecs[1] = '{MK_ONE,  0,   16'h1000, 16'h0000, 12'd300, 12'd10,  0,   512, 2'b10};
      vecs[2] = '{MK_TONE, 256, 16'h1000, 16'h0000, 12'd200, 12'd100, 256, 0,   2'b01};
      vecs[3] = '{MK_TONE, 144, 16'h1000, 16'h0000, 12'd200, 12'd100, 144, 0,   2'b01};
      vecs[4] = '{MK_TONE, 48,  16'h1000, 16'h0000, 12'd200, 12'd100, 48,  0,   2'b00};
      vecs[5] = '{MK_TONE, 144, 16'h1000, 16'h0000, 12'd100, 12'd300, 144, 0,   2'b01};

      RST_i       = 1'b1;
      MIC_i       = 1'b0;
      CONT_i      = 1'b0;
      START_i     = 1'b0;
      TONE_INCs_i = '0;
      THR_ON_i    = '0;
      THR_OFF_i   = '0;
      repeat (3) @(posedge CK_i);
      #1;
      checkOutput("rst_lvs", int'(LVs_o), 0);
      checkOutput("rst_flags", int'(LV_FLGs_o), 0);
      checkOutput("rst_done", DONE_o, 0);
      checkOutput("rst_busy", BUSY_o, 0);
      checkOutput("rst_mic_ck", MIC_CK_o, 0);
      RST_i = 1'b0;

      $display("[TB] free-running divider");
      for (int c = 0; c < 16; c++) begin
         @(posedge CK_i);
         #1;
         checkOutput("mic_ck", MIC_CK_o, (div_m >= C_MIC_DIV / 2) ? 1 : 0);
      end
      checkOutput("idle_lvs", int'(LVs_o), 0);
      checkOutput("idle_busy", BUSY_o, 0);

      $display("[TB] continuous windows from vector table");
      CONT_i = 1'b1;
      for (int v = 0; v < 6; v++) applyStimulus(vecs[v], v == 5);
      smp(1'b0);
      smp(1'b0);
      checkOutput("idle_after_cont", BUSY_o, 0);

      $display("[TB] single-shot with ignored retrigger");
      TONE_INCs_i = {16'h0800, 16'h1000};
      THR_ON_i    = 12'd200;
      THR_OFF_i   = 12'd100;
      sb.push_back('{lv0: 256, lv1: 0, flg: 2'b01});
      busy_cnt = 0;
      START_i  = 1'b1;
      for (int n = 0; n < WIN; n++) begin
         smp(micFor(MK_TONE, 256, n));
         if (n == 0)  START_i = 1'b0;
         if (n == 50) START_i = 1'b1;
         if (n == 60) START_i = 1'b0;
         if (n < WIN - 1 && BUSY_o) busy_cnt++;
      end
      checkOutput("busy_len", busy_cnt, WIN - 1);
      checkOutput("busy_end", BUSY_o, 0);
      for (int n = 0; n < 20; n++) smp(1'b0);
      checkOutput("idle_after_single", BUSY_o, 0);

      $display("[TB] reset in mid-window");
      TONE_INCs_i = {16'h0000, 16'h1000};
      CONT_i      = 1'b1;
      for (int n = 0; n < 100; n++) smp(micFor(MK_TONE, 256, n));
      RST_i = 1'b1;
      repeat (2) begin
         @(posedge CK_i);
         #1;
      end
      checkOutput("mid_rst_lvs", int'(LVs_o), 0);
      checkOutput("mid_rst_flags", int'(LV_FLGs_o), 0);
      checkOutput("mid_rst_done", DONE_o, 0);
      checkOutput("mid_rst_busy", BUSY_o, 0);
      RST_i = 1'b0;
      applyStimulus('{MK_TONE, 144, 16'h1000, 16'h0000, 12'd200, 12'd100, 144, 0, 2'b00}, 1'b1);
      for (int n = 0; n < 3; n++) smp(1'b0);

      checkOutput("scoreboard_empty", sb.size(), 0);
      checkOutput("done_count", n_done, 8);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
